// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline: result-source selects,
// opcode values, ALU operation codes and branch funct3 encodings.
package core_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Writeback result source selects carried down the pipe
   localparam logic [1:0] ALU_RESULT = 2'b00;
   localparam logic [1:0] MEM_TO_REG = 2'b01;
   localparam logic [1:0] PC_PLUS    = 2'b10;

   // ALU operation class produced by the decoder
   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Branch comparison selects (funct3 of B-type instructions)
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Operation performed by the execute-stage ALU
   typedef enum logic [3:0] {
      ADD,
      SUB,
      SLL,
      SLT,
      SLTU,
      XOR,
      SRL,
      SRA,
      OR,
      AND
   } alu_ctrl_t;

   // Evaluate a branch condition; funct3 values 010/011 are not branches
   function automatic logic branch_taken(input logic [2:0]  funct3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic taken;
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (a == b);
         F3_BNE:  taken = (a != b);
         F3_BLT:  taken = ($signed(a) <  $signed(b));
         F3_BGE:  taken = ($signed(a) >= $signed(b));
         F3_BLTU: taken = (a <  b);
         F3_BGEU: taken = (a >= b);
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/stage_execute_alu.sv
// Combinational 32-bit ALU used by the execute stage. Shifts take their
// amount from a dedicated input so I-type shifts need no operand muxing here.
module alu
   import core_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   input  alu_ctrl_t   alu_ctrl,
   output logic [31:0] result
);

   // Select the operation; all arithmetic wraps modulo 2^32
   always_comb begin
      result = '0;
      case (alu_ctrl)
         ADD:     result = a + b;
         SUB:     result = a - b;
         SLL:     result = a << shamt;
         SLT:     result = {31'b0, ($signed(a) < $signed(b))};
         SLTU:    result = {31'b0, (a < b)};
         XOR:     result = a ^ b;
         SRL:     result = a >> shamt;
         SRA:     result = $unsigned($signed(a) >>> shamt);
         OR:      result = a | b;
         AND:     result = a & b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/stage_execute.sv
// Execute stage of the 5-stage RV32I core. Forwards operands from MEM, WB
// and a one-deep WB history, runs the ALU, resolves branches/jumps into a
// PC redirect plus flush, and registers results toward the memory stage.
module stage_execute
   import core_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] decode_instr_addr,
   input  logic [XLEN-1:0] decode_instr_addr_plus,
   input  logic [XLEN-1:0] rs_data1,
   input  logic [XLEN-1:0] rs_data2,
   input  logic [4:0]      decode_rs1,
   input  logic [4:0]      decode_rs2,
   input  logic [4:0]      decode_rd,
   input  logic [1:0]      decode_alu_op,
   input  logic [2:0]      decode_funct3,
   input  logic            decode_funct7b5,
   input  logic [4:0]      decode_shamt,
   input  logic [XLEN-1:0] decode_imm,
   input  logic            decode_alu_src,
   input  logic            decode_jump,
   input  logic            decode_jal_src,
   input  logic            decode_branch,
   input  logic            decode_regfile_wr_enable,
   input  logic            decode_datamem_wr_enable,
   input  logic [1:0]      decode_result_src,
   input  logic [4:0]      mem_rd,
   input  logic            mem_regfile_wr_enable,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [4:0]      wb_wr_addr,
   input  logic [XLEN-1:0] wb_wr_data,
   input  logic            wb_regfile_wr_enable,
   output logic            ex_pc_src,
   output logic [XLEN-1:0] ex_pc_target,
   output logic            ex_flush,
   output logic [XLEN-1:0] ex_alu_result,
   output logic [XLEN-1:0] ex_wr_data,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic [1:0]      ex_result_src,
   output logic            ex_regfile_wr_enable,
   output logic            ex_datamem_wr_enable,
   output logic [XLEN-1:0] ex_instr_addr_plus
);

   // Set for one cycle after a redirect so the wrong-path instruction
   // that slipped into EX is treated as a bubble.
   logic            kill;
   logic            valid;

   // Copy of last cycle's WB write. Decode reads the register file on the
   // same edge WB writes it, so that value can be missing from rs_data.
   logic            hist_en;
   logic [4:0]      hist_addr;
   logic [XLEN-1:0] hist_data;

   logic [XLEN-1:0] fwd1;
   logic [XLEN-1:0] fwd2;
   logic [XLEN-1:0] operand_b;
   logic [4:0]      shift_amount;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] branch_target;
   logic            branch_cond;
   alu_ctrl_t       alu_ctrl;

   // Pick the youngest in-flight value for a source register; x0 never forwards
   function automatic logic [XLEN-1:0] forward_operand(
      input logic [4:0]      rs,
      input logic [XLEN-1:0] rf_data,
      input logic            m_en,
      input logic [4:0]      m_rd,
      input logic [XLEN-1:0] m_data,
      input logic            w_en,
      input logic [4:0]      w_addr,
      input logic [XLEN-1:0] w_data,
      input logic            h_en,
      input logic [4:0]      h_addr,
      input logic [XLEN-1:0] h_data
   );
      logic [XLEN-1:0] value;
      value = rf_data;
      if (rs != 5'd0) begin
         if (m_en && (m_rd == rs)) begin
            value = m_data;
         end else if (w_en && (w_addr == rs)) begin
            value = w_data;
         end else if (h_en && (h_addr == rs)) begin
            value = h_data;
         end
      end
      return value;
   endfunction

   // Resolve both source operands through the forwarding network
   always_comb begin
      fwd1 = forward_operand(decode_rs1, rs_data1,
                             mem_regfile_wr_enable, mem_rd, mem_alu_result,
                             wb_regfile_wr_enable, wb_wr_addr, wb_wr_data,
                             hist_en, hist_addr, hist_data);
      fwd2 = forward_operand(decode_rs2, rs_data2,
                             mem_regfile_wr_enable, mem_rd, mem_alu_result,
                             wb_regfile_wr_enable, wb_wr_addr, wb_wr_data,
                             hist_en, hist_addr, hist_data);
   end

   // Second ALU operand and shift amount follow the immediate select
   always_comb begin
      operand_b    = decode_alu_src ? decode_imm   : fwd2;
      shift_amount = decode_alu_src ? decode_shamt : fwd2[4:0];
   end

   // Translate alu_op/funct3/funct7b5 into a concrete ALU operation.
   // funct7b5 only means SUB for register-register adds, since for ADDI
   // that bit is part of the immediate.
   always_comb begin
      alu_ctrl = ADD;
      case (decode_alu_op)
         ALU_OP_ADD:    alu_ctrl = ADD;
         ALU_OP_BRANCH: alu_ctrl = SUB;
         ALU_OP_FUNCT: begin
            case (decode_funct3)
               3'b000:  alu_ctrl = (decode_funct7b5 && !decode_alu_src) ? SUB : ADD;
               3'b001:  alu_ctrl = SLL;
               3'b010:  alu_ctrl = SLT;
               3'b011:  alu_ctrl = SLTU;
               3'b100:  alu_ctrl = XOR;
               3'b101:  alu_ctrl = decode_funct7b5 ? SRA : SRL;
               3'b110:  alu_ctrl = OR;
               3'b111:  alu_ctrl = AND;
               default: alu_ctrl = ADD;
            endcase
         end
         default:       alu_ctrl = ADD;
      endcase
   end

   alu u_alu (
      .a        (fwd1),
      .b        (operand_b),
      .shamt    (shift_amount),
      .alu_ctrl (alu_ctrl),
      .result   (alu_out)
   );

   // Branch decision and redirect target. B/J immediates arrive without
   // their implicit low zero bit, hence the shift for PC-relative targets.
   always_comb begin
      valid         = !kill;
      branch_cond   = branch_taken(decode_funct3, fwd1, fwd2);
      jalr_sum      = fwd1 + decode_imm;
      branch_target = decode_instr_addr + {decode_imm[XLEN-2:0], 1'b0};
      ex_pc_src     = valid && (decode_jump || (decode_branch && branch_cond));
      ex_flush      = ex_pc_src;
      ex_pc_target  = decode_jal_src ? branch_target : {jalr_sum[XLEN-1:1], 1'b0};
   end

   // Track whether the instruction now in EX is on the wrong path
   always_ff @(posedge clk) begin
      if (rst) begin
         kill <= 1'b0;
      end else begin
         kill <= ex_pc_src;
      end
   end

   // Remember this cycle's WB write for next cycle's forwarding
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_en   <= 1'b0;
         hist_addr <= '0;
         hist_data <= '0;
      end else begin
         hist_en   <= wb_regfile_wr_enable;
         hist_addr <= wb_wr_addr;
         hist_data <= wb_wr_data;
      end
   end

   // EX/MEM pipeline register; bubbles lose their write enables
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_alu_result        <= '0;
         ex_wr_data           <= '0;
         ex_rd                <= '0;
         ex_funct3            <= '0;
         ex_result_src        <= '0;
         ex_regfile_wr_enable <= 1'b0;
         ex_datamem_wr_enable <= 1'b0;
         ex_instr_addr_plus   <= '0;
      end else begin
         ex_alu_result        <= alu_out;
         ex_wr_data           <= fwd2;
         ex_rd                <= decode_rd;
         ex_funct3            <= decode_funct3;
         ex_result_src        <= decode_result_src;
         ex_regfile_wr_enable <= valid && decode_regfile_wr_enable;
         ex_datamem_wr_enable <= valid && decode_datamem_wr_enable;
         ex_instr_addr_plus   <= decode_instr_addr_plus;
      end
   end

endmodule

// File: tb/tb_stage_execute.sv
// Self-checking bench for stage_execute: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_stage_execute;

   typedef struct packed {
      logic        rst;
      logic [31:0] pc;
      logic [31:0] pc_plus;
      logic [31:0] rs_data1;
      logic [31:0] rs_data2;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [1:0]  alu_op;
      logic [2:0]  funct3;
      logic        f7b5;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic        alu_src;
      logic        jump;
      logic        jal_src;
      logic        branch;
      logic        rf_we;
      logic        dm_we;
      logic [1:0]  result_src;
      logic [4:0]  mem_rd;
      logic        mem_we;
      logic [31:0] mem_data;
      logic [4:0]  wb_addr;
      logic        wb_we;
      logic [31:0] wb_data;
   } stim_t;

   typedef struct packed {
      logic        is_reset;
      logic        valid;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  rsrc;
      logic        rfwe;
      logic        dmwe;
      logic [31:0] pcplus;
   } exp_reg_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] decode_instr_addr, decode_instr_addr_plus, rs_data1, rs_data2;
   logic [4:0]  decode_rs1, decode_rs2, decode_rd;
   logic [1:0]  decode_alu_op;
   logic [2:0]  decode_funct3;
   logic        decode_funct7b5;
   logic [4:0]  decode_shamt;
   logic [31:0] decode_imm;
   logic        decode_alu_src, decode_jump, decode_jal_src, decode_branch;
   logic        decode_regfile_wr_enable, decode_datamem_wr_enable;
   logic [1:0]  decode_result_src;
   logic [4:0]  mem_rd;
   logic        mem_regfile_wr_enable;
   logic [31:0] mem_alu_result;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data;
   logic        wb_regfile_wr_enable;
   logic        ex_pc_src, ex_flush;
   logic [31:0] ex_pc_target, ex_alu_result, ex_wr_data, ex_instr_addr_plus;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic [1:0]  ex_result_src;
   logic        ex_regfile_wr_enable, ex_datamem_wr_enable;

   int n_total = 0;
   int n_pass  = 0;

   // Model state: whether last cycle redirected, last cycle's WB write
   logic        m_known = 1'b0, n_known = 1'b0;
   logic        m_kill, n_kill;
   logic        m_hist_we, n_hist_we;
   logic [4:0]  m_hist_addr, n_hist_addr;
   logic [31:0] m_hist_data, n_hist_data;

   // Expectations the compare process reads
   logic        c_known = 1'b0;
   logic        e_pc_src;
   logic [31:0] e_target;
   logic        r_known = 1'b0, p_known = 1'b0;
   exp_reg_t    r_exp, p_exp;
   logic [31:0] m_fwd1, m_fwd2;

   stage_execute #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .decode_instr_addr(decode_instr_addr), .decode_instr_addr_plus(decode_instr_addr_plus),
      .rs_data1(rs_data1), .rs_data2(rs_data2),
      .decode_rs1(decode_rs1), .decode_rs2(decode_rs2), .decode_rd(decode_rd),
      .decode_alu_op(decode_alu_op), .decode_funct3(decode_funct3),
      .decode_funct7b5(decode_funct7b5), .decode_shamt(decode_shamt),
      .decode_imm(decode_imm), .decode_alu_src(decode_alu_src),
      .decode_jump(decode_jump), .decode_jal_src(decode_jal_src), .decode_branch(decode_branch),
      .decode_regfile_wr_enable(decode_regfile_wr_enable),
      .decode_datamem_wr_enable(decode_datamem_wr_enable),
      .decode_result_src(decode_result_src),
      .mem_rd(mem_rd), .mem_regfile_wr_enable(mem_regfile_wr_enable), .mem_alu_result(mem_alu_result),
      .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .wb_regfile_wr_enable(wb_regfile_wr_enable),
      .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target), .ex_flush(ex_flush),
      .ex_alu_result(ex_alu_result), .ex_wr_data(ex_wr_data), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_result_src(ex_result_src),
      .ex_regfile_wr_enable(ex_regfile_wr_enable), .ex_datamem_wr_enable(ex_datamem_wr_enable),
      .ex_instr_addr_plus(ex_instr_addr_plus)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_total = n_total + 1;
      if (actual === expected) begin
         n_pass = n_pass + 1;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Value a source register really holds, youngest producer first
   function automatic logic [31:0] model_operand(input logic [4:0] rs, input logic [31:0] rf, input stim_t s);
      if (rs == 5'd0) return rf;
      if (s.mem_we && s.mem_rd == rs) return s.mem_data;
      if (s.wb_we && s.wb_addr == rs) return s.wb_data;
      if (m_hist_we && m_hist_addr == rs) return m_hist_data;
      return rf;
   endfunction

   // Arithmetic result of the instruction from its decoded fields
   function automatic logic [31:0] model_alu(input stim_t s, input logic [31:0] a, input logic [31:0] r2);
      logic [31:0] b;
      int unsigned sh;
      b  = s.alu_src ? s.imm : r2;
      sh = s.alu_src ? 32'(s.shamt) : 32'(r2[4:0]);
      if (s.alu_op == 2'b00) return a + b;
      if (s.alu_op == 2'b01) return a - b;
      case (s.funct3)
         3'b000: return (s.f7b5 && !s.alu_src) ? a - b : a + b;
         3'b001: return a << sh;
         3'b010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b011: return (a < b) ? 32'd1 : 32'd0;
         3'b100: return a ^ b;
         3'b101: return s.f7b5 ? $unsigned($signed(a) >>> sh) : a >> sh;
         3'b110: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic model_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f3)
         3'b000: return a == b;
         3'b001: return a != b;
         3'b100: return sa < sb;
         3'b101: return sa >= sb;
         3'b110: return a < b;
         3'b111: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // Drive one cycle of inputs and predict what the DUT must do with them
   task automatic apply_stimulus(input stim_t s);
      @(posedge clk);
      #1;
      m_known = n_known;  m_kill = n_kill;
      m_hist_we = n_hist_we;  m_hist_addr = n_hist_addr;  m_hist_data = n_hist_data;
      r_exp = p_exp;  r_known = p_known;

      rst = s.rst;
      decode_instr_addr = s.pc;  decode_instr_addr_plus = s.pc_plus;
      rs_data1 = s.rs_data1;  rs_data2 = s.rs_data2;
      decode_rs1 = s.rs1;  decode_rs2 = s.rs2;  decode_rd = s.rd;
      decode_alu_op = s.alu_op;  decode_funct3 = s.funct3;  decode_funct7b5 = s.f7b5;
      decode_shamt = s.shamt;  decode_imm = s.imm;  decode_alu_src = s.alu_src;
      decode_jump = s.jump;  decode_jal_src = s.jal_src;  decode_branch = s.branch;
      decode_regfile_wr_enable = s.rf_we;  decode_datamem_wr_enable = s.dm_we;
      decode_result_src = s.result_src;
      mem_rd = s.mem_rd;  mem_regfile_wr_enable = s.mem_we;  mem_alu_result = s.mem_data;
      wb_wr_addr = s.wb_addr;  wb_regfile_wr_enable = s.wb_we;  wb_wr_data = s.wb_data;

      m_fwd1   = model_operand(s.rs1, s.rs_data1, s);
      m_fwd2   = model_operand(s.rs2, s.rs_data2, s);
      e_pc_src = !m_kill && (s.jump || (s.branch && model_cond(s.funct3, m_fwd1, m_fwd2)));
      e_target = s.jal_src ? s.pc + (s.imm << 1) : (m_fwd1 + s.imm) & 32'hFFFF_FFFE;
      c_known  = m_known;

      if (s.rst) begin
         p_exp = '0;
         p_exp.is_reset = 1'b1;
         n_kill = 1'b0;  n_hist_we = 1'b0;  n_hist_addr = '0;  n_hist_data = '0;
         n_known = 1'b1;  p_known = 1'b1;
      end else begin
         p_exp.is_reset = 1'b0;
         p_exp.valid  = !m_kill;
         p_exp.alu    = model_alu(s, m_fwd1, m_fwd2);
         p_exp.wdata  = m_fwd2;
         p_exp.rd     = s.rd;
         p_exp.f3     = s.funct3;
         p_exp.rsrc   = s.result_src;
         p_exp.rfwe   = !m_kill && s.rf_we;
         p_exp.dmwe   = !m_kill && s.dm_we;
         p_exp.pcplus = s.pc_plus;
         n_kill = e_pc_src;
         n_hist_we = s.wb_we;  n_hist_addr = s.wb_addr;  n_hist_data = s.wb_data;
         p_known = m_known;
      end
   endtask

   // Compare the DUT against the model every cycle, away from the clock edge
   always @(negedge clk) begin
      if (c_known) begin
         check_output("pc_src", {31'b0, ex_pc_src}, {31'b0, e_pc_src});
         check_output("flush", {31'b0, ex_flush}, {31'b0, e_pc_src});
         if (e_pc_src) check_output("pc_target", ex_pc_target, e_target);
      end
      if (r_known) begin
         check_output("rf_we", {31'b0, ex_regfile_wr_enable}, {31'b0, r_exp.rfwe});
         check_output("dm_we", {31'b0, ex_datamem_wr_enable}, {31'b0, r_exp.dmwe});
         if (r_exp.is_reset || r_exp.valid) begin
            check_output("alu_result", ex_alu_result, r_exp.alu);
            check_output("wr_data", ex_wr_data, r_exp.wdata);
            check_output("rd", {27'b0, ex_rd}, {27'b0, r_exp.rd});
            check_output("funct3", {29'b0, ex_funct3}, {29'b0, r_exp.f3});
            check_output("result_src", {30'b0, ex_result_src}, {30'b0, r_exp.rsrc});
            check_output("instr_addr_plus", ex_instr_addr_plus, r_exp.pcplus);
         end
      end
   end

   function automatic stim_t random_stim();
      stim_t s;
      s = '0;
      s.rst = ($urandom_range(0, 49) == 0);
      s.pc = $urandom & 32'hFFFF_FFFC;  s.pc_plus = s.pc + 4;
      s.rs_data1 = $urandom;  s.rs_data2 = ($urandom_range(0, 3) == 0) ? s.rs_data1 : $urandom;
      s.rs1 = 5'($urandom_range(0, 7));  s.rs2 = 5'($urandom_range(0, 7));  s.rd = 5'($urandom);
      s.alu_op = 2'($urandom_range(0, 2));  s.funct3 = 3'($urandom);  s.f7b5 = 1'($urandom);
      s.shamt = 5'($urandom);  s.imm = $urandom;  s.alu_src = 1'($urandom);
      s.jump = ($urandom_range(0, 5) == 0);  s.jal_src = 1'($urandom);
      s.branch = ($urandom_range(0, 2) == 0);
      s.rf_we = 1'($urandom);  s.dm_we = 1'($urandom);  s.result_src = 2'($urandom_range(0, 2));
      s.mem_rd = 5'($urandom_range(0, 7));  s.mem_we = 1'($urandom);  s.mem_data = $urandom;
      s.wb_addr = 5'($urandom_range(0, 7));  s.wb_we = 1'($urandom);  s.wb_data = $urandom;
      return s;
   endfunction

   initial begin
      stim_t s;
      stim_t idle;
      idle = '0;

      s = idle;  s.rst = 1'b1;
      apply_stimulus(s);
      apply_stimulus(s);

      // ADD x3 = x1 + x2
      s = idle;  s.rs1 = 5'd1;  s.rs2 = 5'd2;  s.rd = 5'd3;
      s.rs_data1 = 32'd5;  s.rs_data2 = 32'd7;  s.alu_op = 2'b10;  s.funct3 = 3'b000;  s.rf_we = 1'b1;
      apply_stimulus(s);
      check_output("pin_add", p_exp.alu, 32'd12);

      // Forward priority MEM > WB > history
      s = idle;  s.rs1 = 5'd4;  s.alu_src = 1'b1;
      s.mem_rd = 5'd4;  s.mem_we = 1'b1;  s.mem_data = 32'h11;
      s.wb_addr = 5'd4;  s.wb_we = 1'b1;  s.wb_data = 32'h22;
      apply_stimulus(s);
      check_output("pin_fwd_mem", m_fwd1, 32'h11);
      s.mem_we = 1'b0;
      apply_stimulus(s);
      check_output("pin_fwd_wb", m_fwd1, 32'h22);
      s = idle;  s.rs1 = 5'd4;  s.alu_src = 1'b1;
      apply_stimulus(s);
      check_output("pin_fwd_hist", m_fwd1, 32'h22);

      // BLT taken, killed follower, BLTU not taken
      s = idle;  s.rs1 = 5'd5;  s.rs2 = 5'd6;  s.rs_data1 = 32'hFFFF_FFFF;  s.rs_data2 = 32'd1;
      s.branch = 1'b1;  s.funct3 = 3'b100;  s.alu_op = 2'b01;  s.pc = 32'h100;  s.imm = 32'd4;  s.jal_src = 1'b1;
      apply_stimulus(s);
      check_output("pin_blt_taken", {31'b0, e_pc_src}, 32'd1);
      check_output("pin_blt_target", e_target, 32'h108);
      s.dm_we = 1'b1;
      apply_stimulus(s);
      check_output("pin_killed", {31'b0, e_pc_src}, 32'd0);
      s.dm_we = 1'b0;  s.funct3 = 3'b110;
      apply_stimulus(s);
      check_output("pin_bltu", {31'b0, e_pc_src}, 32'd0);

      // JALR to 0x203 & ~1
      s = idle;  s.rs1 = 5'd7;  s.rs_data1 = 32'h203;  s.jump = 1'b1;  s.jal_src = 1'b0;
      s.rf_we = 1'b1;  s.rd = 5'd1;  s.result_src = 2'b10;  s.pc_plus = 32'h44;  s.pc = 32'h40;
      apply_stimulus(s);
      check_output("pin_jalr_target", e_target, 32'h202);
      check_output("pin_jalr_wb", {31'b0, p_exp.rfwe}, 32'd1);
      apply_stimulus(idle);

      // SRAI and ADDI with instr[30] set
      s = idle;  s.rs1 = 5'd8;  s.rs_data1 = 32'h8000_0000;  s.alu_op = 2'b10;  s.funct3 = 3'b101;
      s.f7b5 = 1'b1;  s.alu_src = 1'b1;  s.shamt = 5'd4;  s.imm = 32'h404;  s.rf_we = 1'b1;
      apply_stimulus(s);
      check_output("pin_srai", p_exp.alu, 32'hF800_0000);
      s.funct3 = 3'b000;  s.rs_data1 = 32'd10;  s.imm = 32'hFFFF_FFFF;
      apply_stimulus(s);
      check_output("pin_addi", p_exp.alu, 32'd9);

      // Taken branch, then reset, then a normal instruction
      s = idle;  s.branch = 1'b1;  s.funct3 = 3'b000;  s.jal_src = 1'b1;  s.pc = 32'h200;  s.imm = 32'h10;
      apply_stimulus(s);
      s = idle;  s.rst = 1'b1;  s.branch = 1'b1;
      apply_stimulus(s);
      s = idle;  s.rs1 = 5'd2;  s.rs_data1 = 32'd40;  s.alu_src = 1'b1;  s.imm = 32'd2;  s.rf_we = 1'b1;  s.rd = 5'd9;
      apply_stimulus(s);
      check_output("pin_post_reset", p_exp.alu, 32'd42);

      for (int i = 0; i < 600; i++) begin
         apply_stimulus(random_stim());
      end
      apply_stimulus(idle);
      apply_stimulus(idle);
      @(negedge clk);
      #1;
      $display("[TB] %0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
